uart_codec_sequencer: RTL and testbench
=======================================

// Module: uart_codec_sequencer
// PURPOSE
//  Sequences the UART-to-convolutional-encoder datapath: collects NUM_BYTES bytes from
//  async_receiver, feeds them bit-serially into encoder_sys, packs the rate-1/2 output,
//  then streams it back out through async_transmitter using its start/busy handshake.
//  Replaces button-driven buffer handling; sits between RX, encoder_sys and TX in top.
// PARAMETERS
//  NUM_BYTES    4  frame length in received bytes (output frame = 2*NUM_BYTES bytes)
//  ENC_LATENCY  1  cycles from enc_valid to matching enc_out (1..4)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  rx_valid   in   1  one-cycle byte strobe (RxD_data_ready)
//  rx_data    in   8  received byte
//  flush      in   1  synchronous abort/clear (debounced button)
//  k_sel      in   3  requested constraint length, 3..6
//  enc_clear  out  1  one-cycle pulse, clears encoder shift register
//  enc_bit    out  1  bit to encoder
//  enc_valid  out  1  enc_bit qualifier
//  enc_k      out  3  constraint length to encoder, latched per frame
//  enc_out    in   2  encoder output pair
//  tx_start   out  1  one-cycle transmit request
//  tx_data    out  8  byte to transmit, stable from tx_start until busy falls
//  tx_busy    in   1  transmitter busy
//  busy       out  1  high in any state but IDLE/COLLECT
//  overrun    out  1  sticky: rx_valid arrived while busy
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except enc_k=3; counters and buffers cleared.
//  States: IDLE -> COLLECT (first rx_valid) -> CLEAR -> ENCODE -> DRAIN -> SEND -> WAIT_TX -> SEND/IDLE.
//  IDLE/COLLECT: byte n stored at in_buf[8n+7:8n], n = 0..NUM_BYTES-1. On the last byte,
//   next state is CLEAR; the same cycle latches enc_k = k_sel, or 3 if k_sel is outside 3..6.
//  CLEAR: enc_clear=1 for exactly one cycle.
//  ENCODE: 8*NUM_BYTES consecutive cycles, enc_valid=1, enc_bit=in_buf[i], i=0 upward (LSB of byte 0 first).
//  Capture: enc_valid delayed ENC_LATENCY cycles; on each delayed strobe, out_buf[2j+1:2j]=enc_out
//   (enc_out[1] to the higher bit), j = capture index.
//  DRAIN: wait ENC_LATENCY cycles; after the final capture go to SEND.
//  SEND: when tx_busy=0, pulse tx_start with tx_data=out_buf byte m (m=0 first), then WAIT_TX.
//  WAIT_TX: wait for tx_busy to go 1 and then 0 (rise-then-fall, never level-only).
//   Then m++; m==2*NUM_BYTES -> IDLE, otherwise -> SEND.
//  tx_start is never asserted while tx_busy=1 and never on two consecutive cycles.
//  rx_valid in CLEAR..WAIT_TX: byte dropped, overrun<=1. overrun clears only on flush or reset.
//  flush (any state): next cycle IDLE; counters 0; tx_start/enc_valid 0; overrun 0.
//   A byte already in the transmitter is not aborted.
//  flush and rx_valid in the same cycle: flush wins, byte discarded.
//  k_sel changes mid-frame have no effect until the next frame.
//  Reset mid-operation: immediate return to reset values; no partial tx_start glitch.
//  Counter widths: $clog2(8*NUM_BYTES+1) for bits, $clog2(2*NUM_BYTES+1) for bytes.
//   No wrap-around: terminal compares on exact count.
// STRUCTURE
//  codec_pkg: state enum seq_state_t, K_MIN=3, K_MAX=6, K_DEFAULT=3, ENC_RATE=2.
//  Sub-module uart_tx_handshake: owns SEND/WAIT_TX start pulse and busy rise/fall tracking;
//   interface req/ack/data.
//  Capture delay line (ENC_LATENCY deep) and buffers stay in this module.
// TESTING (stub encoder: enc_out={bit,bit}, ENC_LATENCY=1; TX model busy 10 cycles)
//  Bytes 01,00,00,00, k_sel=3 -> tx bytes 03,00,00,00,00,00,00,00; enc_k=3.
//  Bytes FF,FF,00,00 -> tx FF,FF,FF,FF,00,00,00,00; exactly 32 enc_valid cycles after 1 enc_clear.
//  k_sel=7 -> enc_k=3; change k_sel to 5 mid-ENCODE -> enc_k stays 3.
//  Extra rx_valid during SEND -> overrun=1, output bytes unchanged; flush -> overrun=0, state IDLE.
//  Flush after 2 bytes, then AA,55,0F,F0 -> output built from the new 4 bytes only.
//  tx_busy held 1 for 100 cycles -> single tx_start; rst_n low mid-WAIT_TX -> all outputs 0, IDLE.

Source files
------------

// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : codec_pkg
//  Brief    : Shared types and constants for the UART codec sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package codec_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CLEAR   = 3'd2,
    S_ENCODE  = 3'd3,
    S_DRAIN   = 3'd4,
    S_SEND    = 3'd5,
    S_WAIT_TX = 3'd6
  } seq_state_t;

  localparam int K_MIN     = 3;
  localparam int K_MAX     = 6;
  localparam int K_DEFAULT = 3;
  localparam int ENC_RATE  = 2;

  // Out-of-range constraint lengths fall back to the default
  function automatic logic [2:0] k_select(input logic [2:0] k);
    if ((k >= 3'(K_MIN)) && (k <= 3'(K_MAX))) begin
      return k;
    end
    return 3'(K_DEFAULT);
  endfunction

endpackage : codec_pkg
`default_nettype wire

// File: rtl/uart_tx_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_handshake
//  Brief    : Issues one tx_start per request while the transmitter is idle,
//             then tracks busy rise-then-fall and acknowledges completion.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_handshake (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       req_i,
  input  logic [7:0] data_i,
  input  logic       tx_busy_i,
  output logic       launch_o,
  output logic       ack_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o
);

  localparam logic [1:0] HS_IDLE = 2'd0;
  localparam logic [1:0] HS_RISE = 2'd1;
  localparam logic [1:0] HS_FALL = 2'd2;

  logic [1:0] hs_q, hs_d;
  logic       tx_start_q;
  logic [7:0] tx_data_q;

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_q <= HS_IDLE;
    else        hs_q <= hs_d;
  end

  // Next state: launch only when idle, then require busy to rise and fall
  always_comb begin
    hs_d = hs_q;
    if (flush_i) begin
      hs_d = HS_IDLE;
    end else begin
      case (hs_q)
        HS_IDLE: if (req_i && !tx_busy_i) hs_d = HS_RISE;
        HS_RISE: if (tx_busy_i)           hs_d = HS_FALL;
        HS_FALL: if (!tx_busy_i)          hs_d = HS_IDLE;
        default:                          hs_d = HS_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    launch_o = (hs_q == HS_IDLE) && req_i && !tx_busy_i && !flush_i;
    ack_o    = (hs_q == HS_FALL) && !tx_busy_i && !flush_i;
  end

  // Registered start pulse; data held until the next launch so an in-flight byte is undisturbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= launch_o;
      if (launch_o) tx_data_q <= data_i;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule : uart_tx_handshake
`default_nettype wire

// File: rtl/uart_codec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_codec_sequencer
//  Brief    : Collects a frame of UART bytes, streams it bit-serially through
//             the convolutional encoder, packs the rate-1/2 output and sends
//             it back through the UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_codec_sequencer
  import codec_pkg::*;
#(
  parameter int NUM_BYTES   = 4,
  parameter int ENC_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       flush,
  input  logic [2:0] k_sel,
  output logic       enc_clear,
  output logic       enc_bit,
  output logic       enc_valid,
  output logic [2:0] enc_k,
  input  logic [1:0] enc_out,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       overrun
);

  localparam int NBITS = 8 * NUM_BYTES;
  localparam int NOUT  = 2 * NUM_BYTES;
  localparam int OBW   = ENC_RATE * NBITS;
  localparam int RXW   = $clog2(NUM_BYTES + 1);
  localparam int BW    = $clog2(NBITS + 1);
  localparam int MW    = $clog2(NOUT + 1);

  seq_state_t          state_q, state_d;
  logic [RXW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]       cap_cnt_q, cap_cnt_d;
  logic [MW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [NBITS-1:0]    in_buf_q, in_buf_d;
  logic [OBW-1:0]      out_buf_q, out_buf_d;
  logic [2:0]          enc_k_q, enc_k_d;
  logic                overrun_q, overrun_d;
  logic [ENC_LATENCY-1:0] dly_q, w_dly_d;

  logic                w_rx_take, w_rx_last, w_cap, w_launch, w_ack;
  logic [NBITS-1:0]    w_in_shift;
  logic [7:0]          w_tx_byte;

  assign w_rx_take  = rx_valid && !flush && ((state_q == S_IDLE) || (state_q == S_COLLECT));
  assign w_rx_last  = w_rx_take && (rx_cnt_q == RXW'(NUM_BYTES - 1));
  assign w_cap      = dly_q[ENC_LATENCY-1];
  assign w_in_shift = in_buf_q >> bit_cnt_q;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sequencer next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_COLLECT: if (w_rx_take) state_d = w_rx_last ? S_CLEAR : S_COLLECT;
      S_CLEAR:           state_d = S_ENCODE;
      S_ENCODE:          if (bit_cnt_q == BW'(NBITS - 1)) state_d = S_DRAIN;
      S_DRAIN:           if (w_cap && (cap_cnt_q == BW'(NBITS - 1))) state_d = S_SEND;
      S_SEND:            if (w_launch) state_d = S_WAIT_TX;
      S_WAIT_TX:         if (w_ack) state_d = (byte_cnt_q == MW'(NOUT - 1)) ? S_IDLE : S_SEND;
      default:           state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Sequencer outputs decoded from the current state
  always_comb begin
    enc_clear = (state_q == S_CLEAR);
    enc_valid = (state_q == S_ENCODE);
    enc_bit   = (state_q == S_ENCODE) && w_in_shift[0];
    busy      = (state_q != S_IDLE) && (state_q != S_COLLECT);
  end

  // Capture strobe follows enc_valid by the encoder latency; flush kills anything in flight
  generate
    if (ENC_LATENCY == 1) begin : g_dly_one
      assign w_dly_d = enc_valid & ~flush;
    end else begin : g_dly_multi
      assign w_dly_d = {dly_q[ENC_LATENCY-2:0], enc_valid} & {ENC_LATENCY{~flush}};
    end
  endgenerate

  // Output byte currently offered to the transmitter
  always_comb begin
    w_tx_byte = 8'h00;
    for (int m = 0; m < NOUT; m++) begin
      if (byte_cnt_q == MW'(m)) w_tx_byte = out_buf_q[8*m +: 8];
    end
  end

  // Counters, frame buffers, constraint length and overrun flag
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    byte_cnt_d = byte_cnt_q;
    in_buf_d   = in_buf_q;
    out_buf_d  = out_buf_q;
    enc_k_d    = enc_k_q;
    overrun_d  = overrun_q;
    if (flush) begin
      rx_cnt_d   = '0;
      bit_cnt_d  = '0;
      cap_cnt_d  = '0;
      byte_cnt_d = '0;
      in_buf_d   = '0;
      overrun_d  = 1'b0;
    end else begin
      if (w_rx_take) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (rx_cnt_q == RXW'(b)) in_buf_d[8*b +: 8] = rx_data;
        end
        rx_cnt_d = w_rx_last ? '0 : rx_cnt_q + RXW'(1);
        if (w_rx_last) enc_k_d = k_select(k_sel);
      end
      if (rx_valid && busy) overrun_d = 1'b1;
      if (state_q == S_CLEAR) begin
        bit_cnt_d  = '0;
        cap_cnt_d  = '0;
        byte_cnt_d = '0;
      end
      if (state_q == S_ENCODE) bit_cnt_d = bit_cnt_q + BW'(1);
      if (w_cap) begin
        for (int j = 0; j < NBITS; j++) begin
          if (cap_cnt_q == BW'(j)) out_buf_d[ENC_RATE*j +: ENC_RATE] = enc_out;
        end
        cap_cnt_d = cap_cnt_q + BW'(1);
      end
      if (w_ack) byte_cnt_d = byte_cnt_q + MW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      byte_cnt_q <= '0;
      in_buf_q   <= '0;
      out_buf_q  <= '0;
      enc_k_q    <= 3'(K_DEFAULT);
      overrun_q  <= 1'b0;
      dly_q      <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      enc_k_q    <= enc_k_d;
      overrun_q  <= overrun_d;
      dly_q      <= w_dly_d;
    end
  end

  assign enc_k   = enc_k_q;
  assign overrun = overrun_q;

  uart_tx_handshake u_tx_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .req_i     (state_q == S_SEND),
    .data_i    (w_tx_byte),
    .tx_busy_i (tx_busy),
    .launch_o  (w_launch),
    .ack_o     (w_ack),
    .tx_start_o(tx_start),
    .tx_data_o (tx_data)
  );

endmodule : uart_codec_sequencer
`default_nettype wire

// File: tb/tb_uart_codec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_codec_sequencer
//  Brief    : Directed bench for uart_codec_sequencer with a stub encoder
//             (enc_out = {bit,bit}, one cycle latency) and a 10-cycle TX model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_codec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       flush;
  logic [2:0] k_sel;
  logic       enc_clear, enc_bit, enc_valid;
  logic [2:0] enc_k;
  logic [1:0] enc_out;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy, overrun;

  logic       force_busy;
  int         busy_cnt;
  logic [7:0] txq[$];
  int         n_ev, n_ec, viol;
  logic       prev_start;
  int         n_cmp, n_err;

  always #5 clk = ~clk;

  uart_codec_sequencer #(.NUM_BYTES(4), .ENC_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .flush(flush),
    .k_sel(k_sel), .enc_clear(enc_clear), .enc_bit(enc_bit), .enc_valid(enc_valid),
    .enc_k(enc_k), .enc_out(enc_out), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .overrun(overrun)
  );

  // Stub encoder: duplicates the input bit, one cycle of latency
  always @(posedge clk) enc_out <= {enc_bit, enc_bit};

  // Transmitter model: busy for 10 cycles after each start
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  // Monitor sampled mid-cycle
  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      if (tx_busy) viol++;
      if (prev_start) viol++;
    end
    prev_start = tx_start;
    if (enc_valid) n_ev++;
    if (enc_clear) n_ec++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic finish_frame(input int base, input logic [63:0] exp, input string tag);
    int k;
    k = 0;
    while ((txq.size() < base + 8) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_count"}, txq.size() - base, 8);
    k = 0;
    while (busy && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, txq[base+i]}, {24'd0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    int base, ev0, ec0, k;
    n_cmp = 0; n_err = 0; n_ev = 0; n_ec = 0; viol = 0; prev_start = 1'b0;
    busy_cnt = 0; force_busy = 1'b0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; flush = 1'b0; k_sel = 3'd3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_enc_k", {29'd0, enc_k}, 3);
    chk("rst_outs", {26'd0, busy, overrun, tx_start, enc_valid, enc_clear, enc_bit}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);

    // Single set bit in byte 0
    base = txq.size();
    start_frame(32'h00000001);
    finish_frame(base, 64'h00000000_00000003, "f1");
    chk("f1_enc_k", {29'd0, enc_k}, 3);

    // Two bytes of ones; enc_valid/enc_clear counts; k=4 latched
    k_sel = 3'd4;
    base = txq.size(); ev0 = n_ev; ec0 = n_ec;
    start_frame(32'h0000FFFF);
    finish_frame(base, 64'h00000000_FFFFFFFF, "f2");
    chk("f2_enc_valid_cycles", n_ev - ev0, 32);
    chk("f2_enc_clear_cycles", n_ec - ec0, 1);
    chk("f2_enc_k", {29'd0, enc_k}, 4);

    // Out-of-range k falls back to 3; mid-frame change ignored
    k_sel = 3'd7;
    base = txq.size();
    start_frame(32'h00000001);
    k = 0;
    while (!enc_valid && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    chk("f3_encode_seen", {31'd0, enc_valid}, 1);
    k_sel = 3'd5;
    chk("f3_enc_k_mid", {29'd0, enc_k}, 3);
    finish_frame(base, 64'h00000000_00000003, "f3");
    chk("f3_enc_k_end", {29'd0, enc_k}, 3);

    // Extra byte during transmission sets overrun, output unchanged; flush clears it
    k_sel = 3'd3;
    base = txq.size();
    start_frame(32'h04030201);
    k = 0;
    while ((txq.size() <= base) && (k < 500)) begin
      @(negedge clk);
      k++;
    end
    send_byte(8'h77);
    chk("f4_overrun_set", {31'd0, overrun}, 1);
    finish_frame(base, 64'h0030000F_000C0003, "f4");
    chk("f4_overrun_sticky", {31'd0, overrun}, 1);
    pulse_flush();
    chk("f4_overrun_clr", {31'd0, overrun}, 0);
    chk("f4_idle", {31'd0, busy}, 0);

    // Partial frame, flush coinciding with a byte, then a fresh frame
    send_byte(8'h11);
    send_byte(8'h22);
    chk("f5_collect_not_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h99; flush = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; flush = 1'b0;
    chk("f5_after_flush", {30'd0, busy, overrun}, 0);
    base = txq.size();
    start_frame(32'hF00F55AA);
    finish_frame(base, 64'hFF0000FF_3333CCCC, "f5");

    // Transmitter held busy: no start until released, then exactly one
    k_sel = 3'd6;
    force_busy = 1'b1;
    base = txq.size();
    start_frame(32'h0000005A);
    repeat (100) @(negedge clk);
    chk("f6_no_start_held", txq.size() - base, 0);
    chk("f6_busy", {31'd0, busy}, 1);
    chk("f6_enc_k", {29'd0, enc_k}, 6);
    force_busy = 1'b0;
    repeat (5) @(negedge clk);
    chk("f6_single_start", txq.size() - base, 1);

    // Reset while waiting on the transmitter
    rst_n = 1'b0;
    #1;
    chk("f6_rst_outs", {26'd0, busy, overrun, tx_start, enc_valid, enc_clear, enc_bit}, 0);
    chk("f6_rst_enc_k", {29'd0, enc_k}, 3);
    chk("f6_rst_tx_data", {24'd0, tx_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("f6_no_start_after_rst", txq.size() - base, 1);
    chk("protocol_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_codec_sequencer
`default_nettype wire
